// File: rtl/debounce_chaves.sv
// Eight-switch debouncer with a 2-flop synchronizer, a refresh clock divider and per-bit stability counters.
// Latency: 2 clk sync + DEB_CNT clk_div periods (worst case) + 1 clk to a registered ch update.
// Backpressure: none; free-running block with no flow control, and chg is a single-cycle pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   sw_raw   in   [7:0] raw switch levels, asynchronous to clk
//   ch       out  [7:0] debounced switch levels
//   clk_div  out  divided refresh clock, 50% duty, period 2*DIV_HALF clk
//   chg      out  one-clk pulse in the cycle a new ch value first appears
//
// Parameters:
//   DIV_HALF  clk cycles per clk_div half-period (>= 2)
//   DEB_CNT   consecutive mismatching sample ticks required to accept a level (>= 1)

module debounce_chaves #(
    parameter int DIV_HALF = 25000,
    parameter int DEB_CNT  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw_raw,
    output logic [7:0] ch,
    output logic       clk_div,
    output logic       chg
);

    localparam int DIV_W = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
    localparam int CNT_W = (DEB_CNT > 0) ? $clog2(DEB_CNT + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    // ------------------------------------------------------------------
    // Input synchronizer. Only the second stage (sw_s) feeds the logic.
    // ------------------------------------------------------------------
    logic [7:0] r_sync1;
    logic [7:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Refresh divider. clk_div toggles on every counter wrap, so one
    // clk_div period spans two wraps.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_clk_div;
    logic             w_div_wrap;
    logic             w_tick;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);

    // Sample only on the wrap that raises clk_div: one tick per clk_div
    // period, coincident with the rising edge seen by the scan counter.
    assign w_tick = w_div_wrap & ~r_clk_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_clk_div <= 1'b0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_clk_div <= ~r_clk_div;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-bit stability counters. A counter measures how many consecutive
    // ticks the synchronized input has disagreed with the accepted level;
    // any agreeing tick restarts it.
    // ------------------------------------------------------------------
    logic [7:0] r_ch;
    logic [7:0] w_ch_nxt;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;
        logic             w_mis;
        logic             w_done;

        assign w_mis  = r_sync2[gi] ^ r_ch[gi];
        // The counter never passes DEB_CNT-1, so equality marks the
        // DEB_CNT-th consecutive mismatching tick.
        assign w_done = w_mis & (r_cnt == CNT_LAST);

        assign w_ch_nxt[gi] = w_done ? r_sync2[gi] : r_ch[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                if (!w_mis || w_done) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Accepted levels and change pulse. All bits qualifying on the same
    // tick land together, giving a single chg pulse.
    // ------------------------------------------------------------------
    logic r_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch  <= '0;
            r_chg <= 1'b0;
        end else begin
            r_chg <= w_tick & (w_ch_nxt != r_ch);
            if (w_tick) begin
                r_ch <= w_ch_nxt;
            end
        end
    end

    assign ch      = r_ch;
    assign clk_div = r_clk_div;
    assign chg     = r_chg;

endmodule

// File: tb/tb_debounce_chaves.sv
// Self-checking bench for debounce_chaves with DIV_HALF=4, DEB_CNT=3 (one sample tick every 8 clk).
// Latency: checks sampled 1 time unit after each falling clk edge, away from the active edge.
// Backpressure: not applicable; stimulus is free-running.

module tb_debounce_chaves;

    localparam int DIV_HALF = 4;
    localparam int DEB_CNT  = 3;
    localparam int TICK     = 2 * DIV_HALF;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] sw_raw = 8'h00;
    logic [7:0] ch;
    logic       clk_div;
    logic       chg;

    int n_chk  = 0;
    int n_fail = 0;

    debounce_chaves #(
        .DIV_HALF (DIV_HALF),
        .DEB_CNT  (DEB_CNT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_raw  (sw_raw),
        .ch      (ch),
        .clk_div (clk_div),
        .chg     (chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: counts clk edges since reset release, keeps the
    // whole history of raw inputs and of per-tick samples, and accepts a
    // new level when the last DEB_CNT samples taken since the previous
    // acceptance all disagree with the current level.
    // ------------------------------------------------------------------
    logic [7:0] raw_q[$];
    logic [7:0] tick_q[$];
    int         since[8];
    int         n_edge = 0;
    logic [7:0] m_ch   = 8'h00;
    logic       m_chg  = 1'b0;
    logic       m_div  = 1'b0;
    bit         chk_en = 1'b0;

    task automatic model_step();
        logic [7:0] s;
        logic [7:0] nxt;
        logic [7:0] e;
        bit         all_diff;
        if (!rst_n) begin
            n_edge = 0;
            m_ch   = 8'h00;
            m_chg  = 1'b0;
            m_div  = 1'b0;
            raw_q.delete();
            tick_q.delete();
            for (int i = 0; i < 8; i++) since[i] = 0;
        end else begin
            n_edge++;
            raw_q.push_back(sw_raw);
            m_chg = 1'b0;
            if (n_edge % TICK == DIV_HALF) begin
                // Two synchronizer stages: the tick at edge n sees the
                // input captured at edge n-2 (queue index n-3).
                s = raw_q[n_edge - 3];
                tick_q.push_back(s);
                nxt = m_ch;
                for (int i = 0; i < 8; i++) begin
                    since[i]++;
                    if (since[i] >= DEB_CNT) begin
                        all_diff = 1'b1;
                        for (int j = 0; j < DEB_CNT; j++) begin
                            e = tick_q[tick_q.size() - 1 - j];
                            if (e[i] == m_ch[i]) all_diff = 1'b0;
                        end
                        if (all_diff) begin
                            nxt[i]   = ~m_ch[i];
                            since[i] = 0;
                        end
                    end
                end
                m_chg = (nxt != m_ch);
                m_ch  = nxt;
            end
            m_div = ((n_edge / DIV_HALF) % 2) == 1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (chk_en && rst_n) begin
            chk("model_ch", 32'(ch), 32'(m_ch));
            chk("model_clk_div", 32'(clk_div), 32'(m_div));
            chk("model_chg", 32'(chg), 32'(m_chg));
        end
    end

    // ------------------------------------------------------------------
    // Directed vectors: apply sw for cyc clk, then expect ch and the
    // number of chg pulses seen inside that window.
    // ------------------------------------------------------------------
    typedef struct {
        logic [7:0] sw;
        int         cyc;
        logic [7:0] exp_ch;
        int         exp_pulses;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int pulses;
        int rises;
        logic prev3;

        tbl[0] = '{8'h80, 32, 8'h80, 1};  // steady new level accepted
        tbl[1] = '{8'h80, 32, 8'h80, 0};  // stays put
        tbl[2] = '{8'h0F, 16, 8'h80, 0};  // only two mismatching ticks
        tbl[3] = '{8'h80, 16, 8'h80, 0};  // matching ticks restart count
        tbl[4] = '{8'h0F, 32, 8'h0F, 1};  // five bits flip together
        tbl[5] = '{8'hF0, 32, 8'hF0, 1};  // all eight bits flip, one pulse
        tbl[6] = '{8'hFF,  8, 8'hF0, 0};  // single-tick glitch
        tbl[7] = '{8'hF0, 24, 8'hF0, 0};
        tbl[8] = '{8'h00, 40, 8'h00, 1};

        // Reset with all switches high.
        rst_n  = 1'b0;
        sw_raw = 8'hFF;
        repeat (5) @(negedge clk);
        chk("rst_ch", 32'(ch), 32'h00);
        chk("rst_clk_div", 32'(clk_div), 32'h0);
        chk("rst_chg", 32'(chg), 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk($sformatf("div_phase%0d", i), 32'(clk_div), 32'((i / DIV_HALF) % 2));
        end

        // Restart from a clean all-low state.
        rst_n  = 1'b0;
        sw_raw = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            sw_raw = tbl[k].sw;
            pulses = 0;
            repeat (tbl[k].cyc) begin
                @(negedge clk);
                if (chg) pulses++;
            end
            chk($sformatf("vec%0d_ch", k), 32'(ch), 32'(tbl[k].exp_ch));
            chk($sformatf("vec%0d_pulses", k), 32'(pulses), 32'(tbl[k].exp_pulses));
        end

        // Glitch twice on bit 0: the second glitch would qualify if the
        // first had left its count behind.
        pulses = 0;
        repeat (2) begin
            sw_raw = 8'h01;
            repeat (2 * TICK) begin
                @(negedge clk);
                if (chg) pulses++;
            end
            sw_raw = 8'h00;
            repeat (4 * TICK) begin
                @(negedge clk);
                if (chg) pulses++;
            end
        end
        chk("glitch_ch", 32'(ch), 32'h00);
        chk("glitch_pulses", 32'(pulses), 32'h0);

        // Bounce on bit 3, then held high.
        pulses = 0;
        rises  = 0;
        prev3  = ch[3];
        for (int i = 0; i < 60; i++) begin
            if (i < 20) sw_raw[3] = ~sw_raw[3];
            else        sw_raw    = 8'h08;
            @(negedge clk);
            if (chg) pulses++;
            if (ch[3] && !prev3) rises++;
            prev3 = ch[3];
        end
        chk("bounce_ch", 32'(ch), 32'h08);
        chk("bounce_rises", 32'(rises), 32'h1);
        chk("bounce_pulses", 32'(pulses), 32'h1);

        // Reset in the middle of a qualification.
        rst_n  = 1'b0;
        sw_raw = 8'h01;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * TICK) @(negedge clk);
        chk("mid_pre_ch", 32'(ch), 32'h00);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ch", 32'(ch), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= DIV_HALF + 2 * TICK; i++) begin
            @(negedge clk);
            if (i == DIV_HALF + 2 * TICK - 1) chk("mid_before_ch", 32'(ch), 32'h00);
            if (i == DIV_HALF + 2 * TICK) begin
                chk("mid_after_ch", 32'(ch), 32'h01);
                chk("mid_after_chg", 32'(chg), 32'h1);
            end
        end

        // Randomized traffic against the model, with occasional resets.
        for (int s = 0; s < 250; s++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst_n = 1'b1;
            end else if (r < 8) begin
                sw_raw = 8'($urandom);
            end else begin
                sw_raw = sw_raw ^ (8'h01 << $urandom_range(0, 7));
            end
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_chaves.md
DEBOUNCE_CHAVES -- requirements
Module: debounce_chaves

Interface
REQ-001 Parameter DIV_HALF, default 25000, clk cycles per clk_div half-period (50 MHz clk -> 1 kHz clk_div); legal range >= 2.
REQ-002 Parameter DEB_CNT, default 20, consecutive sample ticks a switch level must persist before acceptance; legal range >= 1.
REQ-003 clk  input  1  system clock; sole clock of the block; all flops on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sw_raw  input  8  raw physical switches, asynchronous to clk; bit i = physical chi.
REQ-006 ch  output  8  debounced switch levels; bit i drives input chi of the display mux stage.
REQ-007 clk_div  output  1  divided refresh clock, 50% duty, period 2*DIV_HALF clk cycles; drives the display 2-bit scan counter.
REQ-008 chg  output  1  one-clk pulse, high when any ch bit changes.

Function
REQ-009 Each sw_raw bit SHALL pass through a 2-flop synchronizer; downstream logic SHALL use only the second flop (sw_s).
REQ-010 Divider counter SHALL count 0..DIV_HALF-1 and wrap to 0; width ceil(log2(DIV_HALF)).
REQ-011 clk_div SHALL toggle registered in the clk cycle the divider counter wraps.
REQ-012 Internal sample tick SHALL be high for exactly one clk on each wrap that drives clk_div 0->1, i.e., once per clk_div period.
REQ-013 Each bit i SHALL own a stable counter, width ceil(log2(DEB_CNT+1)), reset 0.
REQ-014 Counter and ch SHALL change only on tick cycles; between ticks they SHALL hold.
REQ-015 On tick with sw_s[i] == ch[i]: counter[i] SHALL clear to 0, ch[i] holds.
REQ-016 On tick with sw_s[i] != ch[i] and counter[i] < DEB_CNT-1: counter[i] SHALL increment, ch[i] holds.
REQ-017 On tick with sw_s[i] != ch[i] and counter[i] == DEB_CNT-1: ch[i] SHALL take sw_s[i] and counter[i] SHALL clear to 0.
REQ-018 Net effect: a level is accepted only after DEB_CNT consecutive mismatching ticks; any matching tick in between restarts the count.
REQ-019 chg SHALL be registered, high in the single clk cycle in which the new ch value first appears, low otherwise.
REQ-020 Multiple bits accepted on the same tick SHALL update ch in the same cycle and produce one chg pulse.
REQ-021 Worst-case input-to-ch latency SHALL be 2 clk (sync) + DEB_CNT clk_div periods + 1 clk.

Reset
REQ-022 rst_n low SHALL immediately clear synchronizer flops, divider counter, all stable counters, ch=8'h00, clk_div=0, chg=0.
REQ-023 Reset mid-operation SHALL discard partial debounce counts; after release a full DEB_CNT-tick qualification is required.
REQ-024 After rst_n rises, first clk_div rise SHALL occur DIV_HALF clk cycles later; rst_n release is synchronized at top level.

Verification (DIV_HALF=4, DEB_CNT=3: tick every 8 clk)
REQ-025 Reset: hold rst_n=0 with sw_raw=8'hFF -> ch=8'h00, clk_div=0, chg=0; release -> clk_div rises after 4 clk, falls after 8, period 8.
REQ-026 Steady input: sw_raw 8'h00->8'h80 held -> ch becomes 8'h80 on the 3rd tick after sw_s[7]=1, chg high exactly that one cycle, ch stable thereafter.
REQ-027 Glitch reject: sw_raw[0]=1 for 2 ticks then 0 -> ch stays 8'h00, chg never asserts; counter[0] back to 0.
REQ-028 Bounce: sw_raw[3] toggling every clk for 20 clk then held 1 -> ch[3] rises exactly once, chg pulses exactly once.
REQ-029 Simultaneous: ch=8'h0F stable, sw_raw->8'hF0 -> all 8 bits change in one cycle to 8'hF0, single chg pulse.
REQ-030 Reset mid-debounce: sw_raw=8'h01 for 2 ticks, pulse rst_n low 1 clk -> ch=8'h00; ch[0] rises only on the 3rd tick after release.
